// File: rtl/if_pkg.sv
// Shared types for the instruction-fetch stage: FSM states, NOP encoding
// and the prefetch queue entry layout.
package if_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FULL  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_e;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// DEPTH-entry synchronous FIFO holding fetched {pc, instr} pairs.
// Flush wins over push; a push into a full queue is rejected and flagged.
module fetch_queue
    import if_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  fq_entry_t     entry_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o,
    output fq_entry_t     head_o
);

    fq_entry_t     mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; the pointers alone define which slots are live.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= entry_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && !flush_i) begin
            assert (!(push_i && full_o))
            else $error("fetch_queue: push into full queue");
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps one request outstanding to
// instruction memory and feeds ID from a small prefetch queue.
module if_fetch_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        id_valid_o,
    output logic [31:0] id_instr_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_pc_plus4_o,
    input  logic        id_ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   drain_addr_q, drain_addr_d;
    logic [31:0]   redirect_tgt;
    logic          q_push, q_pop, q_flush, q_full, q_empty;
    logic [CW-1:0] q_count, count_after;
    fq_entry_t     q_head, q_entry;

    assign redirect_tgt = redirect_pc_i & 32'hFFFF_FFFC;
    assign q_entry      = '{pc: pc_q, instr: imem_rdata_i};
    assign q_pop        = id_valid_o && id_ready_i;

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (q_push),
        .entry_i (q_entry),
        .pop_i   (q_pop),
        .flush_i (q_flush),
        .full_o  (q_full),
        .empty_o (q_empty),
        .count_o (q_count),
        .head_o  (q_head)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        q_push       = 1'b0;
        q_flush      = 1'b0;
        imem_req_o   = 1'b0;
        imem_addr_o  = pc_q;
        count_after  = q_count + CW'(1) - CW'(q_pop);
        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                imem_req_o = 1'b1;
                if (redirect_i) begin
                    q_flush = 1'b1;
                    pc_d    = redirect_tgt;
                    // Without an ack the old request is still in flight and must be drained.
                    if (!imem_ack_i) begin
                        state_d      = DRAIN;
                        drain_addr_d = pc_q;
                    end
                end else if (imem_ack_i) begin
                    q_push = 1'b1;
                    pc_d   = pc_q + 32'd4;
                    if (count_after >= CW'(DEPTH)) state_d = FULL;
                end
            end
            FULL: begin
                if (redirect_i) begin
                    q_flush = 1'b1;
                    pc_d    = redirect_tgt;
                    state_d = FETCH;
                end else if (q_pop || !q_full) begin
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                imem_req_o  = 1'b1;
                imem_addr_o = drain_addr_q;
                if (redirect_i) begin
                    q_flush = 1'b1;
                    pc_d    = redirect_tgt;
                end
                if (imem_ack_i) state_d = FETCH;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_ff @(posedge clk_i) begin
        drain_addr_q <= drain_addr_d;
    end

    assign id_valid_o    = !q_empty;
    assign id_instr_o    = q_empty ? INSTR_NOP : q_head.instr;
    assign id_pc_o       = q_empty ? 32'h0000_0000 : q_head.pc;
    assign id_pc_plus4_o = id_pc_o + 32'd4;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: a memory responder with programmable
// latency, and a scoreboard of expected PCs consumed at the ID handshake.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'h0;
    logic        id_valid_o;
    logic [31:0] id_instr_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_pc_plus4_o;
    logic        id_ready_i = 1'b1;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;

    int          checks = 0;
    int          errors = 0;
    int          lat = 0;
    int          wcnt = 0;
    logic        force_ack = 1'b0;
    logic [31:0] exp_pc_q[$];
    logic [31:0] ack_log[$];
    logic [31:0] sb_e;

    if_fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_rdata_i  (imem_rdata_i),
        .id_valid_o    (id_valid_o),
        .id_instr_o    (id_instr_o),
        .id_pc_o       (id_pc_o),
        .id_pc_plus4_o (id_pc_plus4_o),
        .id_ready_i    (id_ready_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a ^ 32'h1357_9BDF) + 32'h0000_0100;
    endfunction

    function automatic logic [31:0] log_at(input int i);
        if (i < ack_log.size()) return ack_log[i];
        return 32'hxxxx_xxxx;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Memory model: ack after `lat` wait cycles; force_ack injects a stray ack while idle.
    always @(negedge clk) begin
        if (!imem_req_o) begin
            imem_ack_i = force_ack;
            wcnt = 0;
        end else begin
            imem_ack_i = (wcnt >= lat);
            wcnt = imem_ack_i ? 0 : wcnt + 1;
            if (imem_ack_i) ack_log.push_back(imem_addr_o);
        end
        imem_rdata_i = mem_word(imem_addr_o);
    end

    always @(negedge clk) begin
        if (!rst_i && id_valid_o && id_ready_i && !redirect_i) begin
            checks++;
            assert (exp_pc_q.size() != 0)
            else begin
                errors++;
                $error("FAIL sb_unexpected observed pc=%h expected=none", id_pc_o);
            end
            if (exp_pc_q.size() != 0) begin
                sb_e = exp_pc_q.pop_front();
                chk("sb_pc", id_pc_o, sb_e);
                chk("sb_instr", id_instr_o, mem_word(sb_e));
                chk("sb_pc_plus4", id_pc_plus4_o, sb_e + 32'd4);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        cyc(3);
        chk("rst_req", {31'b0, imem_req_o}, 32'd0);
        chk("rst_addr", imem_addr_o, 32'h0);
        chk("rst_valid", {31'b0, id_valid_o}, 32'd0);
        chk("rst_instr", id_instr_o, 32'h0000_0013);
        chk("rst_pc", id_pc_o, 32'h0);
        chk("rst_pc4", id_pc_plus4_o, 32'h4);

        // 1: zero-wait streaming
        ack_log.delete();
        for (int i = 0; i < 4; i++) exp_pc_q.push_back(32'(i * 4));
        rst_i = 1'b0;
        chk("t1_bubble_req", {31'b0, imem_req_o}, 32'd0);
        cyc(1);
        chk("t1_req", {31'b0, imem_req_o}, 32'd1);
        chk("t1_addr0", imem_addr_o, 32'h0);
        chk("t1_valid_early", {31'b0, id_valid_o}, 32'd0);
        cyc(1);
        chk("t1_valid", {31'b0, id_valid_o}, 32'd1);
        chk("t1_pc0", id_pc_o, 32'h0);
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            chk("t1_valid_hold", {31'b0, id_valid_o}, 32'd1);
        end
        id_ready_i = 1'b0;
        chk("t1_log0", log_at(0), 32'h0);
        chk("t1_log1", log_at(1), 32'h4);
        chk("t1_log2", log_at(2), 32'h8);
        rst_i = 1'b1;
        cyc(1);
        chk("t1_sb_left", 32'(exp_pc_q.size()), 32'd0);

        // 2: ID stall fills the queue
        cyc(1);
        ack_log.delete();
        rst_i = 1'b0;
        cyc(4);
        chk("t2_req_full", {31'b0, imem_req_o}, 32'd0);
        chk("t2_head_pc", id_pc_o, 32'h0);
        cyc(2);
        chk("t2_req_full2", {31'b0, imem_req_o}, 32'd0);
        chk("t2_fetch_cnt", 32'(ack_log.size()), 32'd2);
        chk("t2_log0", log_at(0), 32'h0);
        chk("t2_log1", log_at(1), 32'h4);
        exp_pc_q.push_back(32'h0);
        exp_pc_q.push_back(32'h4);
        exp_pc_q.push_back(32'h8);
        id_ready_i = 1'b1;
        cyc(1);
        chk("t2_resume_req", {31'b0, imem_req_o}, 32'd1);
        chk("t2_resume_addr", imem_addr_o, 32'h8);
        chk("t2_head_pc4", id_pc_o, 32'h4);
        cyc(2);
        id_ready_i = 1'b0;
        chk("t2_log2", log_at(2), 32'h8);
        rst_i = 1'b1;
        cyc(1);
        chk("t2_sb_left", 32'(exp_pc_q.size()), 32'd0);

        // 3: redirect while a slow request is outstanding
        lat = 3;
        id_ready_i = 1'b1;
        ack_log.delete();
        exp_pc_q.push_back(32'h100);
        cyc(1);
        rst_i = 1'b0;
        cyc(1);
        chk("t3_addr0", imem_addr_o, 32'h0);
        cyc(1);
        redirect_i = 1'b1;
        redirect_pc_i = 32'h100;
        cyc(1);
        redirect_i = 1'b0;
        chk("t3_drain_req", {31'b0, imem_req_o}, 32'd1);
        chk("t3_drain_addr", imem_addr_o, 32'h0);
        chk("t3_flushed", {31'b0, id_valid_o}, 32'd0);
        cyc(1);
        chk("t3_drain_addr2", imem_addr_o, 32'h0);
        cyc(1);
        chk("t3_new_addr", imem_addr_o, 32'h100);
        chk("t3_no_stale", {31'b0, id_valid_o}, 32'd0);
        cyc(4);
        chk("t3_valid", {31'b0, id_valid_o}, 32'd1);
        chk("t3_pc", id_pc_o, 32'h100);
        cyc(2);
        chk("t3_log0", log_at(0), 32'h0);
        chk("t3_log1", log_at(1), 32'h100);
        rst_i = 1'b1;
        cyc(1);
        chk("t3_sb_left", 32'(exp_pc_q.size()), 32'd0);

        // 4: redirect coincident with ack, unaligned target
        lat = 0;
        ack_log.delete();
        exp_pc_q.push_back(32'h200);
        rst_i = 1'b0;
        cyc(1);
        redirect_i = 1'b1;
        redirect_pc_i = 32'h203;
        cyc(1);
        redirect_i = 1'b0;
        chk("t4_addr", imem_addr_o, 32'h200);
        chk("t4_no_stale", {31'b0, id_valid_o}, 32'd0);
        cyc(1);
        chk("t4_valid", {31'b0, id_valid_o}, 32'd1);
        chk("t4_pc", id_pc_o, 32'h200);
        cyc(1);
        id_ready_i = 1'b0;
        chk("t4_log1", log_at(1), 32'h200);
        rst_i = 1'b1;
        cyc(1);
        chk("t4_sb_left", 32'(exp_pc_q.size()), 32'd0);

        // 5: reset during an outstanding request, then a late ack
        lat = 3;
        id_ready_i = 1'b1;
        ack_log.delete();
        exp_pc_q.push_back(32'h0);
        rst_i = 1'b0;
        cyc(1);
        chk("t5_req", {31'b0, imem_req_o}, 32'd1);
        cyc(1);
        rst_i = 1'b1;
        cyc(1);
        chk("t5_rst_req", {31'b0, imem_req_o}, 32'd0);
        chk("t5_rst_valid", {31'b0, id_valid_o}, 32'd0);
        rst_i = 1'b0;
        force_ack = 1'b1;
        cyc(1);
        force_ack = 1'b0;
        chk("t5_restart_req", {31'b0, imem_req_o}, 32'd1);
        chk("t5_restart_addr", imem_addr_o, 32'h0);
        chk("t5_late_ack_dropped", {31'b0, id_valid_o}, 32'd0);
        cyc(4);
        chk("t5_valid", {31'b0, id_valid_o}, 32'd1);
        chk("t5_pc", id_pc_o, 32'h0);
        cyc(1);
        chk("t5_log0", log_at(0), 32'h0);
        rst_i = 1'b1;
        cyc(1);
        chk("t5_sb_left", 32'(exp_pc_q.size()), 32'd0);

        // 6: PC wraps past the top of the address space
        lat = 0;
        ack_log.delete();
        exp_pc_q.push_back(32'hFFFF_FFFC);
        exp_pc_q.push_back(32'h0);
        rst_i = 1'b0;
        cyc(1);
        redirect_i = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        cyc(1);
        redirect_i = 1'b0;
        chk("t6_addr", imem_addr_o, 32'hFFFF_FFFC);
        cyc(1);
        chk("t6_pc", id_pc_o, 32'hFFFF_FFFC);
        chk("t6_pc4_wrap", id_pc_plus4_o, 32'h0);
        cyc(1);
        chk("t6_pc_next", id_pc_o, 32'h0);
        chk("t6_addr_next", imem_addr_o, 32'h4);
        cyc(1);
        id_ready_i = 1'b0;
        chk("t6_log1", log_at(1), 32'hFFFF_FFFC);
        chk("t6_log2", log_at(2), 32'h0);
        chk("t6_sb_left", 32'(exp_pc_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
